// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Issues one request/acknowledge
// data-memory access per load or store, steers store bytes onto the
// correct lanes, extends load data, and stalls the pipeline until the
// access completes, aborting with a bus error when memory never answers.
module mem_lsu #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_alu_res,
   input  logic [31:0] mem_rs2o,
   input  logic        mem_memwr,
   input  logic        mem_memrd,
   input  logic [2:0]  mem_funct3,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] lsu_rdata,
   output logic        lsu_stall,
   output logic        lsu_misalign,
   output logic        lsu_bus_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state_q;
   logic             req_q;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       be_q;
   logic [31:0]      rdata_q;
   logic             misalign_q;
   logic             bus_err_q;
   logic [CNT_W-1:0] cnt_q;
   // Request-time copies used to extract load data when the ack arrives.
   logic [1:0]       off_q;
   logic [2:0]       funct3_q;
   logic             is_load_q;

   logic             access;
   logic             misaligned;
   logic [31:0]      wdata_d;
   logic [3:0]       be_d;
   logic [31:0]      shifted;
   logic [31:0]      rdata_d;

   assign access = mem_memrd | mem_memwr;

   // Decode the access size of the instruction in MEM: alignment check and store lane steering.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      misaligned = 1'b0;
      wdata_d    = mem_rs2o;
      be_d       = 4'b1111;
      unique case (mem_funct3[1:0])
         2'b00: begin                                   // b / bu
            wdata_d = {4{mem_rs2o[7:0]}};
            be_d    = 4'b0001 << mem_alu_res[1:0];
         end
         2'b01: begin                                   // h / hu
            misaligned = mem_alu_res[0];
            wdata_d    = {2{mem_rs2o[15:0]}};
            be_d       = mem_alu_res[1] ? 4'b1100 : 4'b0011;
         end
         default: begin                                 // w and undefined encodings
            misaligned = |mem_alu_res[1:0];
         end
      endcase
      // Loads read the whole word; stores win when both strobes are set.
      if (!mem_memwr) begin
         be_d = 4'b1111;
      end
   end

   // Extract and extend the addressed bytes of the returned word, using the latched request.
   always_comb begin
      shifted = dmem_rdata >> {off_q, 3'b000};
      rdata_d = shifted;
      unique case (funct3_q)
         3'b000:  rdata_d = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  rdata_d = {24'b0, shifted[7:0]};
         3'b001:  rdata_d = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  rdata_d = {16'b0, shifted[15:0]};
         default: rdata_d = shifted;
      endcase
   end

   // Access sequencer: IDLE issues, WAIT holds the bus until ack or timeout, DONE releases the pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         cnt_q      <= '0;
         off_q      <= '0;
         funct3_q   <= '0;
         is_load_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (access && misaligned) begin
                  misalign_q <= 1'b1;
               end else if (access) begin
                  req_q     <= 1'b1;
                  we_q      <= mem_memwr;
                  addr_q    <= {mem_alu_res[31:2], 2'b00};
                  wdata_q   <= wdata_d;
                  be_q      <= be_d;
                  off_q     <= mem_alu_res[1:0];
                  funct3_q  <= mem_funct3;
                  is_load_q <= ~mem_memwr;
                  cnt_q     <= '0;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dmem_ack) begin
                  req_q   <= 1'b0;
                  if (is_load_q) rdata_q <= rdata_d;
                  state_q <= S_DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  req_q     <= 1'b0;
                  bus_err_q <= 1'b1;
                  if (is_load_q) rdata_q <= '0;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign lsu_stall = (state_q == S_WAIT) ||
                      ((state_q == S_IDLE) && access && !misaligned);

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_be      = be_q;
   assign lsu_rdata    = rdata_q;
   assign lsu_misalign = misalign_q;
   assign lsu_bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a
// behavioural model of the load/store rules and a responding memory.
module tb_mem_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mem_alu_res;
   logic [31:0] mem_rs2o;
   logic        mem_memwr;
   logic        mem_memrd;
   logic [2:0]  mem_funct3;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] lsu_rdata;
   logic        lsu_stall;
   logic        lsu_misalign;
   logic        lsu_bus_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_rdata;

   mem_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_alu_res  (mem_alu_res),
      .mem_rs2o     (mem_rs2o),
      .mem_memwr    (mem_memwr),
      .mem_memrd    (mem_memrd),
      .mem_funct3   (mem_funct3),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_be      (dmem_be),
      .dmem_ack     (dmem_ack),
      .dmem_rdata   (dmem_rdata),
      .lsu_rdata    (lsu_rdata),
      .lsu_stall    (lsu_stall),
      .lsu_misalign (lsu_misalign),
      .lsu_bus_err  (lsu_bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Access width in bytes as seen by the programmer.
   function automatic int nbytes(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
      logic [31:0] sh;
      logic [31:0] b;
      logic [31:0] h;
      sh = word >> (8 * int'(off));
      b  = sh % 32'd256;
      h  = sh % 32'd65536;
      case (f3)
         3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
         3'b100:  return b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b101:  return h;
         default: return sh;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      case (nbytes(f3))
         1:       return (rs2 % 32'd256)   * 32'h0101_0101;
         2:       return (rs2 % 32'd65536) * 32'h0001_0001;
         default: return rs2;
      endcase
   endfunction

   task automatic idle_inputs();
      mem_memrd   = 1'b0;
      mem_memwr   = 1'b0;
      mem_alu_res = $urandom;
      mem_rs2o    = $urandom;
      mem_funct3  = 3'($urandom);
   endtask

   // One instruction in MEM. ack_k = WAIT-cycle index at which memory acks (>= TO means never).
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input int ack_k, input logic [31:0] word);
      int          bytes;
      int          off;
      int          k;
      int          stall_cycles;
      int          exp_cycles;
      bit          done;
      bit          timed;
      logic [31:0] exp_be;
      @(negedge clk);
      mem_memrd   = rd;
      mem_memwr   = wr;
      mem_funct3  = f3;
      mem_alu_res = addr;
      mem_rs2o    = rs2;
      bytes = nbytes(f3);
      off   = int'(addr % 32'd4);
      #1;
      if ((off % bytes) != 0) begin
         check("mis_stall", lsu_stall, 1'b0);
         @(negedge clk);
         check("mis_pulse", lsu_misalign, 1'b1);
         check("mis_req", dmem_req, 1'b0);
         check("mis_rdata", lsu_rdata, exp_rdata);
         idle_inputs();
         #1;
         check("mis_stall2", lsu_stall, 1'b0);
         @(negedge clk);
         check("mis_pulse_end", lsu_misalign, 1'b0);
         check("mis_req2", dmem_req, 1'b0);
         return;
      end
      check("issue_stall", lsu_stall, 1'b1);
      exp_be = wr ? (((32'd1 << bytes) - 32'd1) << off) : 32'hF;
      stall_cycles = 1;
      k     = 0;
      done  = 1'b0;
      timed = 1'b0;
      while (!done) begin
         @(negedge clk);
         check("wait_req", dmem_req, 1'b1);
         check("wait_we", dmem_we, wr);
         check("wait_addr", dmem_addr, addr - (addr % 32'd4));
         check("wait_be", dmem_be, exp_be);
         if (wr) check("wait_wdata", dmem_wdata, ref_wdata(f3, rs2));
         if (lsu_stall === 1'b1) stall_cycles++;
         if (k == ack_k) begin
            dmem_ack   = 1'b1;
            dmem_rdata = word;
            done       = 1'b1;
         end else begin
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (k == TO - 1) begin
               done  = 1'b1;
               timed = 1'b1;
            end
         end
         k++;
      end
      @(negedge clk);
      if (!wr) exp_rdata = timed ? 32'h0 : ref_load(f3, off[1:0], word);
      exp_cycles = 1 + ((ack_k < TO) ? ack_k + 1 : TO);
      check("done_req", dmem_req, 1'b0);
      check("done_stall", lsu_stall, 1'b0);
      check("done_bus_err", lsu_bus_err, timed);
      check("done_rdata", lsu_rdata, exp_rdata);
      check("stall_cycles", stall_cycles, exp_cycles);
      // Memory noise in DONE must be ignored.
      dmem_ack   = 1'($urandom);
      dmem_rdata = $urandom;
      idle_inputs();
      @(negedge clk);
      dmem_ack = 1'b0;
      check("idle_req", dmem_req, 1'b0);
      check("idle_bus_err", lsu_bus_err, 1'b0);
      check("idle_rdata", lsu_rdata, exp_rdata);
   endtask

   initial begin
      logic [2:0] load_f3 [8];
      logic [2:0] store_f3 [3];
      load_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      store_f3 = '{3'b000, 3'b001, 3'b010};

      rst_n      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      idle_inputs();
      exp_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_req", dmem_req, 1'b0);
      check("rst_we", dmem_we, 1'b0);
      check("rst_addr", dmem_addr, 32'h0);
      check("rst_wdata", dmem_wdata, 32'h0);
      check("rst_be", dmem_be, 4'h0);
      check("rst_rdata", lsu_rdata, 32'h0);
      check("rst_misalign", lsu_misalign, 1'b0);
      check("rst_bus_err", lsu_bus_err, 1'b0);
      check("rst_stall", lsu_stall, 1'b0);
      rst_n = 1'b1;

      // Word load, ack one cycle after req rises.
      do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
      check("lw_value", lsu_rdata, 32'hDEADBEEF);
      // Byte/halfword extension.
      do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80112233);
      check("lb_value", lsu_rdata, 32'hFFFFFF80);
      do_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80112233);
      check("lbu_value", lsu_rdata, 32'h00000080);
      do_access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 2, 32'h80112233);
      check("lhu_value", lsu_rdata, 32'h00008011);
      // Halfword store to upper lanes; load result untouched.
      do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0);
      check("sh_wdata", dmem_wdata, 32'hABCDABCD);
      check("sh_be", dmem_be, 4'b1100);
      check("sh_rdata_kept", lsu_rdata, 32'h00008011);
      // Misaligned accesses.
      do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
      do_access(1'b0, 1'b1, 3'b001, 32'h103, 32'h5555AAAA, 0, 32'h0);
      // Timeout on a load.
      do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, TO + 3, 32'h0);
      check("timeout_rdata", lsu_rdata, 32'h0);

      // Reset in the middle of a store's WAIT.
      do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'hCAFEF00D);
      @(negedge clk);
      mem_memwr   = 1'b1;
      mem_funct3  = 3'b010;
      mem_alu_res = 32'h500;
      mem_rs2o    = 32'h01020304;
      @(negedge clk);
      check("rst_mid_req_before", dmem_req, 1'b1);
      #2;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check("rst_mid_req", dmem_req, 1'b0);
      check("rst_mid_stall", lsu_stall, 1'b0);
      check("rst_mid_be", dmem_be, 4'h0);
      check("rst_mid_rdata", lsu_rdata, 32'h0);
      exp_rdata = 32'h0;
      @(negedge clk);
      rst_n      = 1'b1;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      dmem_ack = 1'b0;
      check("late_ack_req", dmem_req, 1'b0);
      check("late_ack_stall", lsu_stall, 1'b0);
      check("late_ack_rdata", lsu_rdata, 32'h0);
      check("late_ack_bus_err", lsu_bus_err, 1'b0);

      // Randomized mix of loads, stores, both-strobe stores, misaligned and timed-out accesses.
      for (int i = 0; i < 200; i++) begin
         int          kind;
         int          ack_k;
         logic [31:0] addr;
         kind  = int'($urandom_range(0, 3));
         ack_k = int'($urandom_range(0, TO + 1));
         addr  = $urandom;
         if (kind == 0) begin
            do_access(1'b1, 1'b0, load_f3[$urandom_range(0, 7)], addr, $urandom, ack_k, $urandom);
         end else if (kind == 1) begin
            do_access(1'b0, 1'b1, store_f3[$urandom_range(0, 2)], addr, $urandom, ack_k, $urandom);
         end else if (kind == 2) begin
            do_access(1'b1, 1'b1, store_f3[$urandom_range(0, 2)], addr, $urandom, ack_k, $urandom);
         end else begin
            // Idle cycle with a stray ack that must not start or complete anything.
            @(negedge clk);
            idle_inputs();
            dmem_ack   = 1'b1;
            dmem_rdata = $urandom;
            #1;
            check("rand_idle_stall", lsu_stall, 1'b0);
            @(negedge clk);
            dmem_ack = 1'b0;
            check("rand_idle_req", dmem_req, 1'b0);
            check("rand_idle_rdata", lsu_rdata, exp_rdata);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
